// File: rtl/mod_dp_pkg.sv
// Shared definitions for the repeated-subtraction modulo unit:
// CU opcodes, CU state encoding and default datapath width.
package mod_dp_pkg;

    localparam int unsigned DP_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_MOD = 2'b00
    } mod_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LOAD_A   = 2'b01,
        SUBTRACT = 2'b10
    } mod_cu_state_e;

endpackage

// File: rtl/mod_sub_cmp.sv
// W-bit unsigned subtractor and less-than comparator shared by the
// modulo datapath.
module mod_sub_cmp
    import mod_dp_pkg::*;
#(
    parameter int unsigned W = DP_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         lt
);

    always_comb begin
        diff = a - b;
        lt   = (a < b);
    end

endmodule

// File: rtl/mod_dp.sv
// Datapath of the repeated-subtraction modulo unit: operand registers,
// step logic, result/flag registers and a saturating iteration counter.
module mod_dp
    import mod_dp_pkg::*;
#(
    parameter int unsigned W      = DP_W_DEFAULT,
    parameter int unsigned ITER_W = W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    input  logic              subtract,
    input  logic [W-1:0]      A,
    input  logic [W-1:0]      B,
    output logic              temp_lt_B,
    output logic [W-1:0]      result,
    output logic              done,
    output logic              div_by_zero,
    output logic [ITER_W-1:0] iter_count
);

    logic [W-1:0]      r_temp;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_result;
    logic              r_done;
    logic              r_div0;
    logic [ITER_W-1:0] r_iter;

    logic [W-1:0]      w_diff;
    logic              w_lt;
    logic              w_b_zero;
    logic              w_temp_lt_b;

    mod_sub_cmp #(.W(W)) u_sub_cmp (
        .a    (r_temp),
        .b    (r_b),
        .diff (w_diff),
        .lt   (w_lt)
    );

    // A zero divisor forces "less than" so the control unit terminates at once.
    always_comb begin
        w_b_zero    = (r_b == '0);
        w_temp_lt_b = w_lt | w_b_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_temp   <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_iter   <= '0;
        end else if (load) begin
            r_temp   <= A;
            r_b      <= B;
            r_result <= '0;
            r_done   <= 1'b0;
            r_div0   <= (B == '0);
            r_iter   <= '0;
        end else if (enable && subtract) begin
            if (!w_temp_lt_b) begin
                r_temp <= w_diff;
                if (r_iter != '1) begin
                    r_iter <= r_iter + ITER_W'(1);
                end
            end else begin
                r_result <= r_temp;
                r_done   <= 1'b1;
            end
        end
    end

    always_comb begin
        temp_lt_B   = w_temp_lt_b;
        result      = r_result;
        done        = r_done;
        div_by_zero = r_div0;
        iter_count  = r_iter;
    end

endmodule

// File: tb/tb_mod_dp.sv
// Directed self-checking bench for mod_dp: one task per scenario with
// hand-computed expectations.
module tb_mod_dp;

    logic       clk;
    logic       reset;
    logic       load;
    logic       enable;
    logic       subtract;
    logic [7:0] A;
    logic [7:0] B;
    logic       temp_lt_B;
    logic [7:0] result;
    logic       done;
    logic       div_by_zero;
    logic [7:0] iter_count;

    int checks = 0;
    int errors = 0;

    mod_dp #(.W(8), .ITER_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .enable      (enable),
        .subtract    (subtract),
        .A           (A),
        .B           (B),
        .temp_lt_B   (temp_lt_B),
        .result      (result),
        .done        (done),
        .div_by_zero (div_by_zero),
        .iter_count  (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic do_load(input logic [7:0] a, input logic [7:0] b);
        load = 1'b1; A = a; B = b;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic cycles(input int n, input logic en, input logic sub);
        enable = en; subtract = sub;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        enable = 1'b0; subtract = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; load = 1'b0; enable = 1'b0; subtract = 1'b0; A = '0; B = '0;
        #12;
        checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", div_by_zero); end
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL reset_iter got %0d exp 0", iter_count); end
        checks++; if (temp_lt_B !== 1'b1) begin errors++; $display("FAIL reset_lt got %b exp 1", temp_lt_B); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        do_load(8'd17, 8'd5);
        checks++; if (temp_lt_B !== 1'b0) begin errors++; $display("FAIL basic_lt0 got %b exp 0", temp_lt_B); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_div0 got %b exp 0", div_by_zero); end
        for (int k = 1; k <= 3; k++) begin
            cycles(1, 1'b1, 1'b1);
            checks++; if (iter_count !== 8'(k)) begin errors++; $display("FAIL basic_iter%0d got %0d exp %0d", k, iter_count, k); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early%0d got %b exp 0", k, done); end
        end
        checks++; if (temp_lt_B !== 1'b1) begin errors++; $display("FAIL basic_lt1 got %b exp 1", temp_lt_B); end
        cycles(1, 1'b1, 1'b1);
        checks++; if (result !== 8'd2) begin errors++; $display("FAIL basic_result got %0d exp 2", result); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end
        checks++; if (iter_count !== 8'd3) begin errors++; $display("FAIL basic_iter_final got %0d exp 3", iter_count); end
        cycles(2, 1'b1, 1'b1);
        checks++; if (result !== 8'd2 || done !== 1'b1 || iter_count !== 8'd3) begin
            errors++; $display("FAIL basic_hold got r=%0d d=%b i=%0d exp r=2 d=1 i=3", result, done, iter_count); end
    endtask

    task automatic test_a_lt_b;
        do_load(8'd3, 8'd7);
        checks++; if (temp_lt_B !== 1'b1) begin errors++; $display("FAIL altb_lt got %b exp 1", temp_lt_B); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL altb_done_cleared got %b exp 0", done); end
        cycles(1, 1'b1, 1'b1);
        checks++; if (result !== 8'd3 || done !== 1'b1 || iter_count !== 8'd0) begin
            errors++; $display("FAIL altb_final got r=%0d d=%b i=%0d exp r=3 d=1 i=0", result, done, iter_count); end
    endtask

    task automatic test_exact;
        do_load(8'd20, 8'd5);
        cycles(4, 1'b1, 1'b1);
        checks++; if (iter_count !== 8'd4) begin errors++; $display("FAIL exact_iter got %0d exp 4", iter_count); end
        checks++; if (temp_lt_B !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL exact_pre got lt=%b d=%b exp lt=1 d=0", temp_lt_B, done); end
        cycles(1, 1'b1, 1'b1);
        checks++; if (result !== 8'd0 || done !== 1'b1) begin
            errors++; $display("FAIL exact_final got r=%0d d=%b exp r=0 d=1", result, done); end
    endtask

    task automatic test_div_zero;
        do_load(8'd9, 8'd0);
        checks++; if (div_by_zero !== 1'b1 || temp_lt_B !== 1'b1) begin
            errors++; $display("FAIL div0_flags got dz=%b lt=%b exp dz=1 lt=1", div_by_zero, temp_lt_B); end
        cycles(1, 1'b1, 1'b1);
        checks++; if (result !== 8'd9 || done !== 1'b1 || iter_count !== 8'd0) begin
            errors++; $display("FAIL div0_final got r=%0d d=%b i=%0d exp r=9 d=1 i=0", result, done, iter_count); end
    endtask

    task automatic test_hold;
        do_load(8'd50, 8'd7);
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL hold_div0_cleared got %b exp 0", div_by_zero); end
        cycles(3, 1'b1, 1'b0);
        cycles(3, 1'b0, 1'b1);
        checks++; if (iter_count !== 8'd0 || done !== 1'b0) begin
            errors++; $display("FAIL hold_idle got i=%0d d=%b exp i=0 d=0", iter_count, done); end
        cycles(7, 1'b1, 1'b1);
        checks++; if (iter_count !== 8'd7 || temp_lt_B !== 1'b1) begin
            errors++; $display("FAIL hold_iter got i=%0d lt=%b exp i=7 lt=1", iter_count, temp_lt_B); end
        cycles(1, 1'b1, 1'b1);
        checks++; if (result !== 8'd1 || done !== 1'b1) begin
            errors++; $display("FAIL hold_final got r=%0d d=%b exp r=1 d=1", result, done); end
    endtask

    task automatic test_max_iter;
        do_load(8'd255, 8'd1);
        cycles(255, 1'b1, 1'b1);
        checks++; if (iter_count !== 8'd255 || temp_lt_B !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL max_iter got i=%0d lt=%b d=%b exp i=255 lt=1 d=0", iter_count, temp_lt_B, done); end
        cycles(1, 1'b1, 1'b1);
        checks++; if (result !== 8'd0 || done !== 1'b1 || iter_count !== 8'd255) begin
            errors++; $display("FAIL max_final got r=%0d d=%b i=%0d exp r=0 d=1 i=255", result, done, iter_count); end
    endtask

    task automatic test_mid_reset;
        do_load(8'd200, 8'd3);
        cycles(2, 1'b1, 1'b1);
        checks++; if (iter_count !== 8'd2) begin errors++; $display("FAIL midrst_pre got %0d exp 2", iter_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (iter_count !== 8'd0 || result !== 8'd0 || done !== 1'b0 || div_by_zero !== 1'b0 || temp_lt_B !== 1'b1) begin
            errors++; $display("FAIL midrst_async got i=%0d r=%0d d=%b dz=%b lt=%b exp 0 0 0 0 1",
                               iter_count, result, done, div_by_zero, temp_lt_B); end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        do_load(8'd10, 8'd4);
        cycles(3, 1'b1, 1'b1);
        checks++; if (result !== 8'd2 || done !== 1'b1 || iter_count !== 8'd2) begin
            errors++; $display("FAIL midrst_reload got r=%0d d=%b i=%0d exp r=2 d=1 i=2", result, done, iter_count); end
    endtask

    task automatic test_load_priority;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL prio_pre_done got %b exp 1", done); end
        load = 1'b1; A = 8'd15; B = 8'd4; enable = 1'b1; subtract = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        checks++; if (iter_count !== 8'd0 || done !== 1'b0 || temp_lt_B !== 1'b0) begin
            errors++; $display("FAIL prio_load got i=%0d d=%b lt=%b exp i=0 d=0 lt=0", iter_count, done, temp_lt_B); end
        cycles(4, 1'b1, 1'b1);
        checks++; if (result !== 8'd3 || done !== 1'b1 || iter_count !== 8'd3) begin
            errors++; $display("FAIL prio_final got r=%0d d=%b i=%0d exp r=3 d=1 i=3", result, done, iter_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_a_lt_b();
        test_exact();
        test_div_zero();
        test_hold();
        test_max_iter();
        test_mid_reset();
        test_load_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
